// File: rtl/buffer_save_reader.sv
// buffer_save_reader: streams a contiguous row range out of the buffer save read port to the save DMA.
// Latency: first beat READ_LATENCY+2 cycles after command accept; one row per cycle thereafter.
// Backpressure: out_ready low fills the local FIFO; issue stops when credit (free FIFO slots) runs out.
//
// Ports:
//   clk, rst                         rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_addr/cmd_len   command handshake (accepted only in IDLE)
//   save_read_addr_valid/save_read_addr    registered read requests to the buffer
//   save_read_data_valid/save_read_data    fixed-latency returned rows (cannot be stalled)
//   out_valid/out_ready/out_data/out_last  row stream to the save DMA
//   done                             one-cycle pulse per completed command
//   err                              sticky flag for a return with nothing in flight
module buffer_save_reader #(
    parameter int BUFFER_ADDR_WIDTH = 11,
    parameter int BUFFER_DATA_WIDTH = 512,
    parameter int READ_LATENCY      = 4,
    parameter int FIFO_DEPTH        = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [BUFFER_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [BUFFER_ADDR_WIDTH:0]   cmd_len,
    output logic                         save_read_addr_valid,
    output logic [BUFFER_ADDR_WIDTH-1:0] save_read_addr,
    input  logic                         save_read_data_valid,
    input  logic [BUFFER_DATA_WIDTH-1:0] save_read_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BUFFER_DATA_WIDTH-1:0] out_data,
    output logic                         out_last,
    output logic                         done,
    output logic                         err
);
    localparam int AW = BUFFER_ADDR_WIDTH;
    localparam int LW = BUFFER_ADDR_WIDTH + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;
    localparam int QW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

    localparam logic [AW-1:0] ONE_A = AW'(1);
    localparam logic [LW-1:0] ONE_L = LW'(1);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [PW-1:0] ONE_P = PW'(1);
    localparam logic [QW-1:0] ONE_Q = QW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   next_addr, next_addr_nxt;
    logic [LW-1:0]   remaining, remaining_nxt;
    logic [LW-1:0]   len_q, len_nxt;
    logic [LW-1:0]   beat_cnt;
    logic [CW-1:0]   inflight;
    logic [QW-1:0]   quiet_cnt;

    logic            cmd_accept;
    logic            issue;
    logic [AW-1:0]   issue_addr;
    logic            done_nxt;
    logic            has_credit;
    logic            quiet;
    logic            ret_accept;
    logic            ret_unexpected;
    logic            beat_xfer;

    // Return FIFO storage
    logic [BUFFER_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]                wr_ptr, rd_ptr;
    logic [CW-1:0]                fifo_count;
    logic                         fifo_empty;

    assign cmd_ready  = (state == IDLE) && !rst;
    assign cmd_accept = cmd_valid && cmd_ready;

    // Every slot is reserved at issue time, so a row landing in the FIFO
    // always has a home even though the buffer cannot be stalled.
    assign has_credit = ({1'b0, fifo_count} + {1'b0, inflight}) < SW'(FIFO_DEPTH);

    // Rows still travelling from before reset arrive during the quiet window
    // and are dropped without flagging an error.
    assign quiet          = (quiet_cnt != '0);
    assign ret_accept     = save_read_data_valid && !quiet && (inflight != '0);
    assign ret_unexpected = save_read_data_valid && !quiet && (inflight == '0);

    assign fifo_empty = (fifo_count == '0);
    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_empty ? '0 : fifo_mem[rd_ptr];
    assign out_last   = out_valid && ((beat_cnt + ONE_L) == len_q);
    assign beat_xfer  = out_valid && out_ready;

    // Next-state, issue decision and done generation
    always_comb begin
        state_nxt     = state;
        next_addr_nxt = next_addr;
        remaining_nxt = remaining;
        len_nxt       = len_q;
        issue         = 1'b0;
        issue_addr    = next_addr;
        done_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_accept) begin
                    len_nxt = cmd_len;
                    if (cmd_len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        // First read is launched in the accept cycle so the
                        // request register shows it the very next cycle.
                        issue         = 1'b1;
                        issue_addr    = cmd_addr;
                        next_addr_nxt = cmd_addr + ONE_A;
                        remaining_nxt = cmd_len - ONE_L;
                        state_nxt     = (cmd_len == ONE_L) ? DRAIN : ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (has_credit) begin
                    issue         = 1'b1;
                    issue_addr    = next_addr;
                    next_addr_nxt = next_addr + ONE_A;
                    remaining_nxt = remaining - ONE_L;
                    if (remaining == ONE_L) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The final beat is the last row of the command; once it
                // leaves, nothing is in flight and the FIFO is empty.
                if (beat_xfer && out_last) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            next_addr            <= '0;
            remaining            <= '0;
            len_q                <= '0;
            beat_cnt             <= '0;
            inflight             <= '0;
            quiet_cnt            <= QW'(READ_LATENCY);
            save_read_addr_valid <= 1'b0;
            save_read_addr       <= '0;
            done                 <= 1'b0;
            err                  <= 1'b0;
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            fifo_count           <= '0;
        end else begin
            state                <= state_nxt;
            next_addr            <= next_addr_nxt;
            remaining            <= remaining_nxt;
            len_q                <= len_nxt;
            save_read_addr_valid <= issue;
            done                 <= done_nxt;

            if (issue) begin
                save_read_addr <= issue_addr;
            end

            // inflight counts reads from the decision cycle until their return
            case ({issue, ret_accept})
                2'b10:   inflight <= inflight + ONE_C;
                2'b01:   inflight <= inflight - ONE_C;
                default: inflight <= inflight;
            endcase

            if (quiet) begin
                quiet_cnt <= quiet_cnt - ONE_Q;
            end

            if (ret_unexpected) begin
                err <= 1'b1;
            end

            if (cmd_accept) begin
                beat_cnt <= '0;
            end else if (beat_xfer) begin
                beat_cnt <= beat_cnt + ONE_L;
            end

            if (ret_accept) begin
                wr_ptr <= wr_ptr + ONE_P;
            end
            if (beat_xfer) begin
                rd_ptr <= rd_ptr + ONE_P;
            end
            case ({ret_accept, beat_xfer})
                2'b10:   fifo_count <= fifo_count + ONE_C;
                2'b01:   fifo_count <= fifo_count - ONE_C;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset; the count and pointers define what is valid.
    // A write into the slot being popped is safe: the head is read before the edge.
    always_ff @(posedge clk) begin
        if (ret_accept) begin
            fifo_mem[wr_ptr] <= save_read_data;
        end
    end

endmodule

// File: tb/tb_buffer_save_reader.sv
module tb_buffer_save_reader;
    localparam int AW = 11;
    localparam int DW = 512;
    localparam int RL = 4;
    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic          save_read_addr_valid;
    logic [AW-1:0] save_read_addr;
    logic          save_read_data_valid;
    logic [DW-1:0] save_read_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;
    logic          err;
    logic          inj;

    buffer_save_reader #(
        .BUFFER_ADDR_WIDTH(AW),
        .BUFFER_DATA_WIDTH(DW),
        .READ_LATENCY(RL),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .save_read_addr_valid(save_read_addr_valid),
        .save_read_addr(save_read_addr),
        .save_read_data_valid(save_read_data_valid),
        .save_read_data(save_read_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: fixed-latency pipeline returning data = address.
    logic [RL:1]   pv = '0;
    logic [AW-1:0] pa [1:RL];
    always @(posedge clk) begin
        pv[1] <= save_read_addr_valid;
        pa[1] <= save_read_addr;
        for (int k = 2; k <= RL; k++) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
        end
    end
    assign save_read_data_valid = pv[RL] | inj;
    assign save_read_data       = DW'(pa[RL]);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard
    typedef struct packed {
        logic          last;
        logic [AW-1:0] addr;
    } beat_t;

    beat_t         exp_beats[$];
    logic [AW-1:0] exp_addr[$];

    int issued = 0;
    int beats = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_cyc = 0;
    int first_addr_cyc = -1;
    int last_addr_cyc = 0;
    int stall_cyc = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(negedge clk) begin : mon
        beat_t e;
        if (rst) begin
            issued     = 0;
            beats      = 0;
            prev_stall = 1'b0;
            exp_beats.delete();
            exp_addr.delete();
        end else begin
            if (save_read_addr_valid) begin
                if (first_addr_cyc < 0) first_addr_cyc = cyc;
                last_addr_cyc = cyc;
                issued++;
                check("addr_has_expect", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0) check("read_addr", save_read_addr, exp_addr.pop_front());
                check("credit_bound", (issued - beats) <= FD, 1);
            end
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data[63:0], prev_data[63:0]);
                check("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                beats++;
                check("beat_has_expect", exp_beats.size() != 0, 1);
                if (exp_beats.size() != 0) begin
                    e = exp_beats.pop_front();
                    check("beat_data", out_data[63:0], 64'(e.addr));
                    check("beat_hi", |out_data[DW-1:64], 0);
                    check("beat_last", out_last, e.last);
                end
                if (out_last) last_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (prev_stall) stall_cyc++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    int t_acc = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(a + AW'(i));
            exp_beats.push_back(beat_t'{last: (i == n - 1), addr: a + AW'(i)});
        end
        cmd_addr  = a;
        cmd_len   = (AW + 1)'(n);
        cmd_valid = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!cmd_ready && w < 50);
        check("cmd_accept", cmd_ready, 1);
        t_acc = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit);
        int w;
        w = 0;
        while (done_cnt < target && w < limit) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("done_seen", done_cnt, target);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int rd_before;
        int dc_before;
        int beats_before;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        out_ready = 1'b1;
        inj       = 1'b0;

        // Reset values
        tick(1);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_addr_valid", save_read_addr_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        tick(1);
        rst = 1'b0;
        #1;
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_addr", save_read_addr, 0);
        check("idle_out_data", out_data[63:0], 0);
        check("idle_out_last", out_last, 0);

        // Basic command
        send_cmd(11'h010, 4);
        wait_done(1, 100);
        check("first_addr_cyc", first_addr_cyc, t_acc + 1);
        check("last_addr_cyc", last_addr_cyc, t_acc + 4);
        check("basic_last_cyc", last_cyc, t_acc + 4 + RL + 1);
        check("basic_done_cyc", done_cyc, t_acc + 4 + RL + 2);
        tick(3);
        check("basic_done_once", done_cnt, 1);
        check("basic_err", err, 0);
        check("basic_sb_empty", exp_beats.size(), 0);

        // Zero-length command
        rd_before = issued;
        send_cmd(11'h020, 0);
        wait_done(2, 20);
        check("len0_done_cyc", done_cyc, t_acc + 1);
        tick(4);
        check("len0_no_reads", issued, rd_before);

        // Back-pressure mid-stream
        send_cmd(11'h100, 20);
        tick(8);
        out_ready = 1'b0;
        tick(10);
        out_ready = 1'b1;
        wait_done(3, 300);
        check("bp_stall_cycles", stall_cyc, 10);
        check("bp_sb_empty", exp_beats.size(), 0);
        check("bp_addr_empty", exp_addr.size(), 0);
        check("bp_err", err, 0);

        // Address wrap
        send_cmd(11'h7FE, 4);
        wait_done(4, 100);
        check("wrap_last_cyc", last_cyc, t_acc + 4 + RL + 1);
        check("wrap_sb_empty", exp_beats.size(), 0);

        // Full buffer length
        send_cmd(11'h123, 2048);
        wait_done(5, 3000);
        check("full_last_cyc", last_cyc, t_acc + 2048 + RL + 1);
        check("full_sb_empty", exp_beats.size(), 0);
        check("full_err", err, 0);

        // Spurious return in IDLE
        tick(6);
        beats_before = beats;
        inj = 1'b1;
        tick(1);
        inj = 1'b0;
        tick(1);
        check("spur_err_set", err, 1);
        tick(5);
        check("spur_err_sticky", err, 1);
        check("spur_no_valid", out_valid, 0);
        check("spur_no_beat", beats, beats_before);

        // Reset during DRAIN with three reads in flight
        dc_before = done_cnt;
        send_cmd(11'h200, 8);
        tick(9);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        #1;
        check("mid_cmd_ready", cmd_ready, 1);
        check("mid_addr_valid", save_read_addr_valid, 0);
        check("mid_addr", save_read_addr, 0);
        check("mid_out_valid", out_valid, 0);
        check("mid_out_last", out_last, 0);
        check("mid_done", done, 0);
        check("mid_err", err, 0);
        tick(6);
        check("mid_err_late", err, 0);
        check("mid_no_beat", out_valid, 0);
        check("mid_no_done", done_cnt, dc_before);

        send_cmd(11'h050, 2);
        wait_done(dc_before + 1, 100);
        check("post_last_cyc", last_cyc, t_acc + 2 + RL + 1);
        check("post_sb_empty", exp_beats.size(), 0);
        check("post_err", err, 0);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
